// File: rtl/interboard_pkg.sv
// Shared definitions for the interboard link: message-type codes, message width
// and the link FSM state type used by both the transmit scheduler and the receiver.
package interboard_pkg;

    localparam int MSG_W = 8;

    localparam logic [2:0] MSG_NOP     = 3'd0;
    localparam logic [2:0] MSG_MOVE    = 3'd1;
    localparam logic [2:0] MSG_ATTACK  = 3'd2;
    localparam logic [2:0] MSG_SCORE   = 3'd3;
    localparam logic [2:0] MSG_STATE   = 3'd4;
    localparam logic [2:0] MSG_ACK     = 3'd5;
    localparam logic [2:0] MSG_SYNC    = 3'd6;
    localparam logic [2:0] MSG_RESTART = 3'd7;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } link_state_t;

    // A message travels as {type, number}.
    function automatic logic [MSG_W-1:0] pack_msg(input logic [2:0] msg_type,
                                                  input logic [4:0] number);
        return {msg_type, number};
    endfunction

endpackage

// File: rtl/msg_fifo.sv
// Synchronous FIFO with first-word fall-through read data and a synchronous flush.
// A push into a full FIFO is only taken when a pop happens in the same cycle.
module msg_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_PTR = AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign w_do_pop  = pop && (r_count != '0);
    assign w_do_push = push && ((r_count != FULL_CNT) || w_do_pop);

    assign dout  = r_mem[r_rd_ptr];
    assign full  = (r_count == FULL_CNT);
    assign empty = (r_count == '0);
    assign count = r_count;

    always_ff @(posedge clk) begin
        if (w_do_push && !flush) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + ONE_PTR;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + ONE_PTR;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + ONE_CNT;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - ONE_CNT;
            end
        end
    end

endmodule

// File: rtl/interboard_tx_scheduler.sv
// Transmit scheduler: queues game and system messages, arbitrates with system priority,
// and walks the link sender through transmit / inter_ready with timeout re-issue.
module interboard_tx_scheduler #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   interboard_rst,
    input  logic                   game_en,
    input  logic [2:0]             game_msg_type,
    input  logic [4:0]             game_number,
    output logic                   game_full,
    input  logic                   sys_en,
    input  logic [2:0]             sys_msg_type,
    input  logic [4:0]             sys_number,
    output logic                   sys_busy,
    input  logic                   inter_ready,
    output logic                   transmit,
    output logic                   ctrl_en,
    output logic [2:0]             ctrl_msg_type,
    output logic [4:0]             ctrl_number,
    output logic [$clog2(DEPTH):0] pending,
    output logic [7:0]             drop_cnt
);

    import interboard_pkg::*;

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] TO_ONE  = CW'(1);

    link_state_t            r_state;
    link_state_t            w_next_state;
    logic [CW-1:0]          r_timer;
    logic [CW-1:0]          w_timer_next;
    logic                   r_sys_valid;
    logic [MSG_W-1:0]       r_sys_msg;
    logic [MSG_W-1:0]       r_hold;
    logic                   r_transmit;
    logic                   r_ctrl_en;
    logic [7:0]             r_drop_cnt;
    logic                   w_sel_sys;
    logic                   w_sel_game;
    logic                   w_fifo_push;
    logic [MSG_W-1:0]       w_fifo_dout;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic [$clog2(DEPTH):0] w_fifo_count;
    logic                   w_game_drop;
    logic                   w_sys_drop;
    logic [8:0]             w_drop_sum;

    assign w_fifo_push = game_en && !interboard_rst;

    msg_fifo #(
        .WIDTH (MSG_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (interboard_rst),
        .push  (w_fifo_push),
        .pop   (w_sel_game),
        .din   (pack_msg(game_msg_type, game_number)),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

    always_comb begin
        w_next_state = r_state;
        w_timer_next = r_timer;
        w_sel_sys    = 1'b0;
        w_sel_game   = 1'b0;
        case (r_state)
            IDLE: begin
                if (inter_ready) begin
                    if (r_sys_valid) begin
                        w_sel_sys    = 1'b1;
                        w_next_state = ISSUE;
                    end else if (!w_fifo_empty) begin
                        w_sel_game   = 1'b1;
                        w_next_state = ISSUE;
                    end
                end
            end
            ISSUE: begin
                w_timer_next = '0;
                w_next_state = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!inter_ready) begin
                    w_next_state = WAIT_DONE;
                end else if (r_timer == TO_LAST) begin
                    w_next_state = ISSUE;
                end else begin
                    w_timer_next = r_timer + TO_ONE;
                end
            end
            WAIT_DONE: begin
                if (inter_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
        if (interboard_rst) begin
            w_next_state = IDLE;
            w_sel_sys    = 1'b0;
            w_sel_game   = 1'b0;
        end
    end

    // Drops are pushes that find no room even after this cycle's pop.
    assign w_game_drop = game_en && !interboard_rst && w_fifo_full && !w_sel_game;
    assign w_sys_drop  = sys_en && !interboard_rst && r_sys_valid && !w_sel_sys;
    assign w_drop_sum  = {1'b0, r_drop_cnt} + {8'd0, w_game_drop} + {8'd0, w_sys_drop};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_timer    <= '0;
            r_sys_valid <= 1'b0;
            r_sys_msg  <= '0;
            r_hold     <= '0;
            r_transmit <= 1'b0;
            r_ctrl_en  <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_state    <= w_next_state;
            r_timer    <= w_timer_next;
            r_transmit <= (w_next_state == ISSUE);
            r_ctrl_en  <= (w_next_state != IDLE);

            if (w_sel_sys) begin
                r_hold <= r_sys_msg;
            end else if (w_sel_game) begin
                r_hold <= w_fifo_dout;
            end

            if (interboard_rst) begin
                r_sys_valid <= 1'b0;
            end else if (sys_en && (!r_sys_valid || w_sel_sys)) begin
                r_sys_valid <= 1'b1;
                r_sys_msg   <= pack_msg(sys_msg_type, sys_number);
            end else if (w_sel_sys) begin
                r_sys_valid <= 1'b0;
            end

            if (w_drop_sum > 9'd255) begin
                r_drop_cnt <= 8'hFF;
            end else begin
                r_drop_cnt <= w_drop_sum[7:0];
            end
        end
    end

    assign transmit      = r_transmit;
    assign ctrl_en       = r_ctrl_en;
    assign ctrl_msg_type = r_hold[7:5];
    assign ctrl_number   = r_hold[4:0];
    assign game_full     = w_fifo_full;
    assign sys_busy      = r_sys_valid;
    assign pending       = w_fifo_count;
    assign drop_cnt      = r_drop_cnt;

endmodule

// File: tb/tb_interboard_tx_scheduler.sv
// Directed bench for interboard_tx_scheduler: a vector table for the basic flow and
// FIFO overflow, then hand-written sequences for priority, timeout, flush and drop counting.
module tb_interboard_tx_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       interboardRst;
    logic       gameEn;
    logic [2:0] gameType;
    logic [4:0] gameNum;
    logic       gameFull;
    logic       sysEn;
    logic [2:0] sysType;
    logic [4:0] sysNum;
    logic       sysBusy;
    logic       interReady;
    logic       transmit;
    logic       ctrlEn;
    logic [2:0] ctrlType;
    logic [4:0] ctrlNum;
    logic [2:0] pending;
    logic [7:0] dropCnt;

    int assertCount = 0;
    int failCount   = 0;
    int expDrop     = 0;

    typedef struct {
        logic       gEn;
        logic [2:0] gType;
        logic [4:0] gNum;
        logic       sEn;
        logic [2:0] sType;
        logic [4:0] sNum;
        logic       ir;
        logic       irst;
        logic       xTx;
        logic       xEn;
        logic [2:0] xType;
        logic [4:0] xNum;
        logic       xFull;
        logic       xBusy;
        logic [2:0] xPend;
        logic [7:0] xDrop;
    } vec_t;

    vec_t vecs[$];

    interboard_tx_scheduler #(
        .DEPTH   (4),
        .TIMEOUT (15)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .interboard_rst (interboardRst),
        .game_en        (gameEn),
        .game_msg_type  (gameType),
        .game_number    (gameNum),
        .game_full      (gameFull),
        .sys_en         (sysEn),
        .sys_msg_type   (sysType),
        .sys_number     (sysNum),
        .sys_busy       (sysBusy),
        .inter_ready    (interReady),
        .transmit       (transmit),
        .ctrl_en        (ctrlEn),
        .ctrl_msg_type  (ctrlType),
        .ctrl_number    (ctrlNum),
        .pending        (pending),
        .drop_cnt       (dropCnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Inputs change just after a rising edge; outputs are sampled 1 time unit after the next one.
    task automatic applyStimulus(input logic gE, input logic [2:0] gT, input logic [4:0] gN,
                                 input logic sE, input logic [2:0] sT, input logic [4:0] sN,
                                 input logic ir, input logic irst);
        gameEn        = gE;
        gameType      = gT;
        gameNum       = gN;
        sysEn         = sE;
        sysType       = sT;
        sysNum        = sN;
        interReady    = ir;
        interboardRst = irst;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle(input logic ir);
        applyStimulus(1'b0, 3'd0, 5'd0, 1'b0, 3'd0, 5'd0, ir, 1'b0);
    endtask

    task automatic gamePush(input logic [2:0] t, input logic [4:0] n, input logic ir);
        applyStimulus(1'b1, t, n, 1'b0, 3'd0, 5'd0, ir, 1'b0);
    endtask

    task automatic sysPush(input logic [2:0] t, input logic [4:0] n, input logic ir);
        applyStimulus(1'b0, 3'd0, 5'd0, 1'b1, t, n, ir, 1'b0);
    endtask

    // From ISSUE: sender goes busy, then idle again, FSM back in IDLE.
    task automatic finishMsg();
        idleCycle(1'b1);
        idleCycle(1'b0);
        idleCycle(1'b1);
        checkOutput("finish ctrl_en", ctrlEn, 1'b0);
    endtask

    task automatic expectNext(input logic [2:0] t, input logic [4:0] n, input logic [2:0] pend);
        idleCycle(1'b1);
        checkOutput($sformatf("next %0d/%0d transmit", t, n), transmit, 1'b1);
        checkOutput($sformatf("next %0d/%0d ctrl_en", t, n), ctrlEn, 1'b1);
        checkOutput($sformatf("next %0d/%0d type", t, n), ctrlType, t);
        checkOutput($sformatf("next %0d/%0d number", t, n), ctrlNum, n);
        checkOutput($sformatf("next %0d/%0d pending", t, n), pending, pend);
        finishMsg();
    endtask

    task automatic addVec(input logic gE, input logic [2:0] gT, input logic [4:0] gN,
                          input logic sE, input logic [2:0] sT, input logic [4:0] sN,
                          input logic ir, input logic irst,
                          input logic xTx, input logic xEn, input logic [2:0] xType,
                          input logic [4:0] xNum, input logic xFull, input logic xBusy,
                          input logic [2:0] xPend, input logic [7:0] xDrop);
        vec_t v;
        v.gEn = gE;   v.gType = gT;   v.gNum = gN;
        v.sEn = sE;   v.sType = sT;   v.sNum = sN;
        v.ir  = ir;   v.irst  = irst;
        v.xTx = xTx;  v.xEn   = xEn;  v.xType = xType; v.xNum = xNum;
        v.xFull = xFull; v.xBusy = xBusy; v.xPend = xPend; v.xDrop = xDrop;
        vecs.push_back(v);
    endtask

    initial begin
        rst           = 1'b1;
        interboardRst = 1'b0;
        gameEn        = 1'b0;
        gameType      = 3'd0;
        gameNum       = 5'd0;
        sysEn         = 1'b0;
        sysType       = 3'd0;
        sysNum        = 5'd0;
        interReady    = 1'b1;

        // Single game message with a well-behaved sender.
        addVec(1,3,17, 0,0,0, 1,0,  0,0,3'd0,5'd0,  0,0,3'd1,8'd0);
        addVec(0,0,0,  0,0,0, 1,0,  1,1,3'd3,5'd17, 0,0,3'd0,8'd0);
        addVec(0,0,0,  0,0,0, 1,0,  0,1,3'd3,5'd17, 0,0,3'd0,8'd0);
        for (int i = 0; i < 10; i++)
            addVec(0,0,0, 0,0,0, 0,0,  0,1,3'd3,5'd17, 0,0,3'd0,8'd0);
        addVec(0,0,0,  0,0,0, 1,0,  0,0,3'd3,5'd17, 0,0,3'd0,8'd0);

        // Overfill with the sender busy, then drain in order.
        for (int k = 1; k <= 4; k++)
            addVec(1,3'(k),5'(10+k), 0,0,0, 0,0,  0,0,3'd3,5'd17, (k == 4),0,3'(k),8'd0);
        addVec(1,5,15, 0,0,0, 0,0,  0,0,3'd3,5'd17, 1,0,3'd4,8'd1);
        for (int k = 1; k <= 4; k++) begin
            addVec(0,0,0, 0,0,0, 1,0,  1,1,3'(k),5'(10+k), 0,0,3'(4-k),8'd1);
            addVec(0,0,0, 0,0,0, 1,0,  0,1,3'(k),5'(10+k), 0,0,3'(4-k),8'd1);
            addVec(0,0,0, 0,0,0, 0,0,  0,1,3'(k),5'(10+k), 0,0,3'(4-k),8'd1);
            addVec(0,0,0, 0,0,0, 1,0,  0,0,3'(k),5'(10+k), 0,0,3'(4-k),8'd1);
        end

        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("reset transmit", transmit, 1'b0);
        checkOutput("reset ctrl_en", ctrlEn, 1'b0);
        checkOutput("reset ctrl_msg_type", ctrlType, 3'd0);
        checkOutput("reset ctrl_number", ctrlNum, 5'd0);
        checkOutput("reset game_full", gameFull, 1'b0);
        checkOutput("reset sys_busy", sysBusy, 1'b0);
        checkOutput("reset pending", pending, 3'd0);
        checkOutput("reset drop_cnt", dropCnt, 8'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].gEn, vecs[i].gType, vecs[i].gNum,
                          vecs[i].sEn, vecs[i].sType, vecs[i].sNum,
                          vecs[i].ir, vecs[i].irst);
            checkOutput($sformatf("vec%0d transmit", i), transmit, vecs[i].xTx);
            checkOutput($sformatf("vec%0d ctrl_en", i), ctrlEn, vecs[i].xEn);
            checkOutput($sformatf("vec%0d type", i), ctrlType, vecs[i].xType);
            checkOutput($sformatf("vec%0d number", i), ctrlNum, vecs[i].xNum);
            checkOutput($sformatf("vec%0d game_full", i), gameFull, vecs[i].xFull);
            checkOutput($sformatf("vec%0d sys_busy", i), sysBusy, vecs[i].xBusy);
            checkOutput($sformatf("vec%0d pending", i), pending, vecs[i].xPend);
            checkOutput($sformatf("vec%0d drop_cnt", i), dropCnt, vecs[i].xDrop);
        end
        expDrop = 1;

        // Full FIFO: pop and push in the same cycle keeps occupancy, no drop.
        for (int k = 0; k < 4; k++)
            gamePush(3'd1, 5'(20+k), 1'b0);
        checkOutput("popush full before", gameFull, 1'b1);
        gamePush(3'd2, 5'd24, 1'b1);
        checkOutput("popush transmit", transmit, 1'b1);
        checkOutput("popush number", ctrlNum, 5'd20);
        checkOutput("popush pending", pending, 3'd4);
        checkOutput("popush game_full", gameFull, 1'b1);
        checkOutput("popush drop_cnt", dropCnt, expDrop);
        finishMsg();
        expectNext(3'd1, 5'd21, 3'd3);
        expectNext(3'd1, 5'd22, 3'd2);
        expectNext(3'd1, 5'd23, 3'd1);
        expectNext(3'd2, 5'd24, 3'd0);

        // System message arriving in WAIT_DONE overtakes queued game messages.
        gamePush(3'd2, 5'd5, 1'b0);
        gamePush(3'd2, 5'd6, 1'b0);
        gamePush(3'd2, 5'd7, 1'b0);
        idleCycle(1'b1);
        checkOutput("prio first number", ctrlNum, 5'd5);
        checkOutput("prio first pending", pending, 3'd2);
        idleCycle(1'b1);
        idleCycle(1'b0);
        sysPush(3'd7, 5'd0, 1'b0);
        checkOutput("prio sys_busy set", sysBusy, 1'b1);
        checkOutput("prio still waiting", ctrlEn, 1'b1);
        idleCycle(1'b1);
        expectNext(3'd7, 5'd0, 3'd2);
        checkOutput("prio sys_busy clear", sysBusy, 1'b0);
        expectNext(3'd2, 5'd6, 3'd1);
        expectNext(3'd2, 5'd7, 3'd0);

        // Occupied slot keeps its message; game and system drops together add 2.
        sysPush(3'd6, 5'd1, 1'b0);
        sysPush(3'd6, 5'd2, 1'b0);
        expDrop = expDrop + 1;
        checkOutput("slot drop drop_cnt", dropCnt, expDrop);
        for (int k = 1; k <= 4; k++)
            gamePush(3'd3, 5'(k), 1'b0);
        applyStimulus(1'b1, 3'd3, 5'd9, 1'b1, 3'd6, 5'd3, 1'b0, 1'b0);
        expDrop = expDrop + 2;
        checkOutput("double drop drop_cnt", dropCnt, expDrop);
        expectNext(3'd6, 5'd1, 3'd4);
        for (int k = 1; k <= 4; k++)
            expectNext(3'd3, 5'(k), 3'(4-k));

        // Sender never goes busy: re-issue every TIMEOUT+1 cycles with the same message.
        gamePush(3'd4, 5'd9, 1'b1);
        idleCycle(1'b1);
        checkOutput("timeout first transmit", transmit, 1'b1);
        for (int r = 0; r < 2; r++) begin
            for (int i = 1; i <= 15; i++) begin
                idleCycle(1'b1);
                checkOutput($sformatf("timeout gap r%0d c%0d", r, i), transmit, 1'b0);
            end
            idleCycle(1'b1);
            checkOutput($sformatf("timeout retry%0d transmit", r), transmit, 1'b1);
            checkOutput($sformatf("timeout retry%0d ctrl_en", r), ctrlEn, 1'b1);
            checkOutput($sformatf("timeout retry%0d type", r), ctrlType, 3'd4);
            checkOutput($sformatf("timeout retry%0d number", r), ctrlNum, 5'd9);
        end
        finishMsg();

        // Peer flush during WAIT_BUSY with queued entries and pushes in the same cycle.
        for (int k = 1; k <= 4; k++)
            gamePush(3'd5, 5'(k), 1'b0);
        idleCycle(1'b1);
        idleCycle(1'b1);
        checkOutput("flush pre ctrl_en", ctrlEn, 1'b1);
        checkOutput("flush pre pending", pending, 3'd3);
        applyStimulus(1'b1, 3'd5, 5'd9, 1'b1, 3'd7, 5'd7, 1'b1, 1'b1);
        checkOutput("flush transmit", transmit, 1'b0);
        checkOutput("flush ctrl_en", ctrlEn, 1'b0);
        checkOutput("flush pending", pending, 3'd0);
        checkOutput("flush sys_busy", sysBusy, 1'b0);
        checkOutput("flush drop_cnt", dropCnt, expDrop);
        checkOutput("flush ctrl_number kept", ctrlNum, 5'd1);
        idleCycle(1'b1);
        checkOutput("flush after transmit", transmit, 1'b0);
        checkOutput("flush after ctrl_en", ctrlEn, 1'b0);

        // Drop counter saturation.
        for (int k = 0; k < 4; k++)
            gamePush(3'd0, 5'(k), 1'b0);
        sysPush(3'd0, 5'd0, 1'b0);
        for (int i = 0; i < 125; i++)
            applyStimulus(1'b1, 3'd1, 5'd1, 1'b1, 3'd1, 5'd1, 1'b0, 1'b0);
        checkOutput("sat drop_cnt 254", dropCnt, 8'd254);
        applyStimulus(1'b1, 3'd1, 5'd1, 1'b1, 3'd1, 5'd1, 1'b0, 1'b0);
        checkOutput("sat drop_cnt 255", dropCnt, 8'd255);
        applyStimulus(1'b1, 3'd1, 5'd1, 1'b1, 3'd1, 5'd1, 1'b0, 1'b0);
        checkOutput("sat drop_cnt hold", dropCnt, 8'd255);
        applyStimulus(1'b0, 3'd0, 5'd0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b1);
        checkOutput("sat flush drop_cnt", dropCnt, 8'd255);
        checkOutput("sat flush pending", pending, 3'd0);

        // Asynchronous reset takes effect between clock edges.
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async reset drop_cnt", dropCnt, 8'd0);
        checkOutput("async reset ctrl_number", ctrlNum, 5'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
